db3_gen: RTL and testbench

DB3_GEN -- requirements
Module: db3_gen

---
 rtl/db3_gen.sv | 140 ++++++++++++++
 tb/tb_db3_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/db3_gen.sv
// Output-layer delta-bias generator: db_k = -(eta * (y_k - t_k) * y_k * (1 - y_k)) in Q6.10,
// evaluated for both neurons in turn on a single shared 16x16 signed multiplier.
module db3_gen (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] y3_1,
  input  logic signed [15:0] y3_2,
  input  logic signed [15:0] t_1,
  input  logic signed [15:0] t_2,
  input  logic signed [15:0] eta,
  output logic signed [15:0] db3_1,
  output logic signed [15:0] db3_2,
  output logic               busy,
  output logic               done,
  output logic               select_update
);

  typedef enum logic [2:0] {IDLE, LOAD, MUL1, MUL2, MUL3, DONE} state_t;

  state_t state_reg, state_next;
  logic   k2_reg;  // 0 selects neuron 1, 1 selects neuron 2

  logic signed [15:0] y1_reg, y2_reg, t1_reg, t2_reg, eta_reg;
  logic signed [15:0] e1_reg, e2_reg, omy1_reg, omy2_reg;
  logic signed [15:0] m1_reg, m2_reg, db1_reg, db2_reg;

  logic signed [15:0] mul_a, mul_b, prod_q;
  logic signed [31:0] product;

  function automatic logic signed [15:0] sat17(input logic signed [16:0] v);
    if (v > 17'sd32767)       return 16'sh7FFF;
    else if (v < -17'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // Back to Q6.10: floor shift by 10, then clamp to the 16-bit range.
  function automatic logic signed [15:0] scale_sat(input logic signed [31:0] p);
    logic signed [31:0] s;
    s = p >>> 10;
    if (s > 32'sd32767)       return 16'sh7FFF;
    else if (s < -32'sd32768) return 16'sh8000;
    else                      return s[15:0];
  endfunction

  function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
    if (v == 16'sh8000) return 16'sh7FFF;
    else                return -v;
  endfunction

  // Operand select for the shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      MUL1: begin
        mul_a = k2_reg ? y2_reg : y1_reg;
        mul_b = k2_reg ? omy2_reg : omy1_reg;
      end
      MUL2: begin
        mul_a = k2_reg ? e2_reg : e1_reg;
        mul_b = m1_reg;
      end
      MUL3: begin
        mul_a = eta_reg;
        mul_b = m2_reg;
      end
      default: ;
    endcase
  end

  assign product = mul_a * mul_b;
  assign prod_q  = scale_sat(product);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = MUL1;
      MUL1:    state_next = MUL2;
      MUL2:    state_next = MUL3;
      MUL3:    state_next = k2_reg ? DONE : MUL1;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      k2_reg    <= 1'b0;
      y1_reg    <= '0;
      y2_reg    <= '0;
      t1_reg    <= '0;
      t2_reg    <= '0;
      eta_reg   <= '0;
      e1_reg    <= '0;
      e2_reg    <= '0;
      omy1_reg  <= '0;
      omy2_reg  <= '0;
      m1_reg    <= '0;
      m2_reg    <= '0;
      db1_reg   <= '0;
      db2_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          y1_reg  <= y3_1;
          y2_reg  <= y3_2;
          t1_reg  <= t_1;
          t2_reg  <= t_2;
          eta_reg <= eta;
        end
        LOAD: begin
          k2_reg   <= 1'b0;
          e1_reg   <= sat17($signed({y1_reg[15], y1_reg}) - $signed({t1_reg[15], t1_reg}));
          e2_reg   <= sat17($signed({y2_reg[15], y2_reg}) - $signed({t2_reg[15], t2_reg}));
          omy1_reg <= sat17(17'sd1024 - $signed({y1_reg[15], y1_reg}));
          omy2_reg <= sat17(17'sd1024 - $signed({y2_reg[15], y2_reg}));
        end
        MUL1: m1_reg <= prod_q;
        MUL2: m2_reg <= prod_q;
        MUL3: begin
          if (k2_reg) db2_reg <= neg_sat(prod_q);
          else        db1_reg <= neg_sat(prod_q);
          k2_reg <= ~k2_reg;
        end
        default: ;
      endcase
    end
  end

  assign db3_1         = db1_reg;
  assign db3_2         = db2_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign select_update = done;

endmodule

// File: tb/tb_db3_gen.sv
// Directed testbench for db3_gen: latency, arithmetic, saturation, reset and start handling.
module tb_db3_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic signed [15:0] y3_1 = '0, y3_2 = '0, t_1 = '0, t_2 = '0, eta = '0;
  logic signed [15:0] db3_1, db3_2;
  logic busy, done, select_update;

  int checks = 0;
  int failures = 0;

  db3_gen dut (
    .clk(clk), .reset(reset), .start(start),
    .y3_1(y3_1), .y3_2(y3_2), .t_1(t_1), .t_2(t_2), .eta(eta),
    .db3_1(db3_1), .db3_2(db3_2),
    .busy(busy), .done(done), .select_update(select_update)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input int a1, input int b1, input int a2, input int b2, input int lr);
    y3_1 = 16'(a1); t_1 = 16'(b1); y3_2 = 16'(a2); t_2 = 16'(b2); eta = 16'(lr);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (db3_1 !== 16'sd0 || db3_2 !== 16'sd0 || busy !== 1'b0 || done !== 1'b0 || select_update !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got db1=%0d db2=%0d busy=%b done=%b sel=%b exp all zero",
               db3_1, db3_2, busy, done, select_update);
    end
    reset = 1'b0;
    tick();
    $display("reset: db3_1=%0d db3_2=%0d busy=%b", db3_1, db3_2, busy);
  endtask

  // Cycle-accurate latency check: values sampled after edge E0+i.
  task automatic test_nominal();
    int n_done = 0;
    logic signed [15:0] exp1, exp2;
    set_inputs(512, 0, 512, 0, 512);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp1 = (i >= 4) ? -16'sd64 : 16'sd0;
      exp2 = (i >= 7) ? -16'sd64 : 16'sd0;
      checks++;
      if (done !== (i == 7) || select_update !== (i == 7) || busy !== (i < 8)) begin
        failures++;
        $display("FAIL nominal_ctrl cyc=%0d got done=%b sel=%b busy=%b exp done=%b sel=%b busy=%b",
                 i, done, select_update, busy, (i == 7), (i == 7), (i < 8));
      end
      checks++;
      if (db3_1 !== exp1 || db3_2 !== exp2) begin
        failures++;
        $display("FAIL nominal_data cyc=%0d got db1=%0d db2=%0d exp db1=%0d db2=%0d",
                 i, db3_1, db3_2, exp1, exp2);
      end
      if (done) n_done++;
    end
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL nominal_done_count got %0d exp 1", n_done);
    end
    $display("nominal: db3_1=%0d db3_2=%0d dones=%0d", db3_1, db3_2, n_done);
  endtask

  task automatic test_zero_error();
    int n_done = 0;
    set_inputs(700, 700, -300, -300, 1024);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (select_update !== done || done !== (i == 7)) begin
        failures++;
        $display("FAIL zero_done cyc=%0d got done=%b sel=%b exp both %b", i, done, select_update, (i == 7));
      end
      if (done) n_done++;
    end
    checks++;
    if (db3_1 !== 16'sd0 || db3_2 !== 16'sd0 || n_done != 1) begin
      failures++;
      $display("FAIL zero_data got db1=%0d db2=%0d dones=%0d exp 0 0 1", db3_1, db3_2, n_done);
    end
    $display("zero_error: db3_1=%0d db3_2=%0d dones=%0d", db3_1, db3_2, n_done);
  endtask

  task automatic test_saturation();
    set_inputs(4096, 0, 512, 0, 1024);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    checks++;
    if (db3_1 !== 16'sh7FFF) begin
      failures++;
      $display("FAIL sat_db1 got %0d exp 32767", db3_1);
    end
    checks++;
    if (db3_2 !== -16'sd128) begin
      failures++;
      $display("FAIL sat_db2 got %0d exp -128", db3_2);
    end
    $display("saturation: db3_1=%0d db3_2=%0d", db3_1, db3_2);
  endtask

  task automatic test_reset_mid_run();
    int n_done = 0;
    set_inputs(512, 0, 512, 0, 512);
    start = 1'b1;
    tick();                 // E0
    start = 1'b0;
    tick();                 // E0+1
    reset = 1'b1;
    tick();                 // E0+2
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || db3_1 !== 16'sd0 || db3_2 !== 16'sd0) begin
      failures++;
      $display("FAIL midreset_state got busy=%b done=%b db1=%0d db2=%0d exp 0 0 0 0",
               busy, done, db3_1, db3_2);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) n_done++;
    end
    checks++;
    if (n_done != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_done got dones=%0d busy=%b exp 0 0", n_done, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (done) n_done++;
    end
    checks++;
    if (db3_1 !== -16'sd64 || db3_2 !== -16'sd64 || n_done != 1) begin
      failures++;
      $display("FAIL midreset_rerun got db1=%0d db2=%0d dones=%0d exp -64 -64 1", db3_1, db3_2, n_done);
    end
    $display("reset_mid_run: db3_1=%0d db3_2=%0d dones=%0d", db3_1, db3_2, n_done);
  endtask

  task automatic test_ignored_start();
    int n_done = 0;
    set_inputs(512, 0, 512, 0, 1024);
    start = 1'b1;
    tick();                 // E0
    start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 1) y3_1 = 16'sd4096;
      start = (i == 3 || i == 8);
      tick();
      checks++;
      if (busy !== (i < 8)) begin
        failures++;
        $display("FAIL ignore_busy cyc=%0d got %b exp %b", i, busy, (i < 8));
      end
      if (done) n_done++;
    end
    start = 1'b0;
    checks++;
    if (db3_1 !== -16'sd128 || db3_2 !== -16'sd128 || n_done != 1) begin
      failures++;
      $display("FAIL ignore_result got db1=%0d db2=%0d dones=%0d exp -128 -128 1", db3_1, db3_2, n_done);
    end
    $display("ignored_start: db3_1=%0d db3_2=%0d dones=%0d", db3_1, db3_2, n_done);
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] exp1, exp2;
    set_inputs(4096, 0, 512, 0, 1024);
    start = 1'b1;
    tick();                 // E0
    for (int i = 1; i <= 19; i++) begin
      if (i == 1) y3_1 = 16'sd512;
      tick();
      exp1 = (i < 4) ? -16'sd128 : ((i < 13) ? 16'sh7FFF : -16'sd128);
      exp2 = -16'sd128;
      checks++;
      if (done !== (i == 7 || i == 16)) begin
        failures++;
        $display("FAIL b2b_done cyc=%0d got %b exp %b", i, done, (i == 7 || i == 16));
      end
      checks++;
      if (db3_1 !== exp1 || db3_2 !== exp2) begin
        failures++;
        $display("FAIL b2b_data cyc=%0d got db1=%0d db2=%0d exp db1=%0d db2=%0d",
                 i, db3_1, db3_2, exp1, exp2);
      end
    end
    start = 1'b0;
    repeat (12) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got busy=%b exp 0", busy);
    end
    $display("back_to_back: db3_1=%0d db3_2=%0d", db3_1, db3_2);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_error();
    test_saturation();
    test_reset_mid_run();
    test_ignored_start();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
